wildeq_scan: RTL and testbench
==============================

WILDEQ_SCAN -- requirements
Module: wildeq_scan

Interface
REQ-001 Parameter WIDTH, default 4, key/pattern width in bits (1..64).
REQ-002 Parameter ENTRIES, default 8, pattern table depth (power of two, 2..64); IW = log2(ENTRIES).
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cfg_we  input  1  pattern table write strobe.
REQ-006 cfg_ready  output  1  table write accepted this cycle when high with cfg_we.
REQ-007 cfg_idx  input  IW  entry index to write.
REQ-008 cfg_en  input  1  entry valid bit to store.
REQ-009 cfg_val  input  WIDTH  pattern value.
REQ-010 cfg_mask  input  WIDTH  wildcard bits; 1 = don't-care (the "?" positions).
REQ-011 req_valid / req_ready  input / output  1  lookup request handshake.
REQ-012 req_key  input  WIDTH  key to match.
REQ-013 rsp_valid / rsp_ready  output / input  1  result handshake.
REQ-014 rsp_hit  output  1  1 = some valid entry matched.
REQ-015 rsp_idx  output  IW  lowest matching index; 0 when rsp_hit = 0.

Function
REQ-016 Entry i matches key k iff en[i] = 1 and ((k ^ val[i]) & ~mask[i]) == 0, i.e. k ==? pattern with ? at mask bits.
REQ-017 States: IDLE, SCAN, RESP; one compare unit evaluates exactly one entry per SCAN cycle, pointer ptr from 0 upward.
REQ-018 IDLE: cfg_ready = 1; req_ready = ~cfg_we; a table write takes priority over a same-cycle request.
REQ-019 IDLE and req_valid and req_ready: latch req_key, clear ptr, hit flag and idx; go SCAN.
REQ-020 SCAN: cfg_ready = 0, req_ready = 0; on match at ptr with no prior hit, record hit = 1, idx = ptr.
REQ-021 SCAN exits to RESP after ptr = ENTRIES-1 is evaluated (or earlier per REQ-030); ptr does not wrap.
REQ-022 RESP: rsp_valid = 1, rsp_hit/rsp_idx stable; cfg_ready = 0, req_ready = 0; on rsp_ready go IDLE.
REQ-023 Latency with request accepted at cycle T: miss -> rsp_valid first high at T+1+ENTRIES.
REQ-024 Backpressure: rsp_valid held, outputs unchanged, for any number of cycles until rsp_ready.
REQ-025 No back-to-back overlap: next request accepted no earlier than the cycle after the rsp handshake.
REQ-026 Table writes take effect the cycle after acceptance; a write never alters an in-progress scan (writes blocked outside IDLE).

Reset
REQ-027 rst high: state IDLE, all en[i] = 0, ptr = 0, rsp_valid = 0, rsp_hit = 0, rsp_idx = 0; val/mask contents need not reset.
REQ-028 rst mid-SCAN or mid-RESP abandons the lookup; no rsp_valid is produced for it.
REQ-029 Outputs after reset deassertion: cfg_ready = 1, req_ready = 1 (when cfg_we = 0), rsp_valid = 0.

Configuration
REQ-030 Macro WILDEQ_SCAN_EARLY_EXIT_EN defined: SCAN exits on first hit; hit at entry k -> rsp_valid first high at T+2+k.
REQ-031 Macro undefined: SCAN always evaluates all ENTRIES; rsp_valid at T+1+ENTRIES for hit and miss (fixed latency); hit/idx still lowest index.

Verification
REQ-032 Reset, write idx 3 val 4'b1000 mask 4'b0110 en 1, key 4'b1010 -> rsp_hit 1, rsp_idx 3; latency T+5 with EARLY_EXIT, T+9 without.
REQ-033 Same table, key 4'b1011 -> rsp_hit 0, rsp_idx 0 at T+9 in both builds.
REQ-034 idx 1 val 4'b0000 mask 4'b1111, idx 3 as above, key 4'b1010 -> rsp_idx 1 (priority); idx 1 written en 0 -> rsp_idx 3.
REQ-035 cfg_we and req_valid both high in IDLE -> write accepted, req_ready 0; request accepted next cycle and sees the new entry.
REQ-036 Hold rsp_ready 0 for 5 cycles -> rsp_valid/hit/idx stable, req_ready 0; rst asserted during SCAN -> no rsp_valid, all en cleared.

Source files
------------

// File: rtl/wildeq_scan_if.sv
// ---------------------------------------------------------------------------
// wildeq_scan_if
// Purpose : bundles the pattern-table write port, the lookup request
//           handshake and the lookup result handshake of wildeq_scan.
// Params  : WIDTH   key/pattern width in bits
//           ENTRIES pattern table depth (power of two)
// Signals : cfg_we/cfg_ready, cfg_idx, cfg_en, cfg_val, cfg_mask  table write
//           req_valid/req_ready, req_key                          lookup request
//           rsp_valid/rsp_ready, rsp_hit, rsp_idx                 lookup result
// Modports: master drives writes/requests and accepts results,
//           slave is the scanner side.
// ---------------------------------------------------------------------------
interface wildeq_scan_if #(
   parameter int WIDTH   = 4,
   parameter int ENTRIES = 8
);
   localparam int IW = $clog2(ENTRIES);

   logic             cfg_we;
   logic             cfg_ready;
   logic [IW-1:0]    cfg_idx;
   logic             cfg_en;
   logic [WIDTH-1:0] cfg_val;
   logic [WIDTH-1:0] cfg_mask;

   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_key;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_hit;
   logic [IW-1:0]    rsp_idx;

   modport master (
      output cfg_we, cfg_idx, cfg_en, cfg_val, cfg_mask,
      output req_valid, req_key, rsp_ready,
      input  cfg_ready, req_ready, rsp_valid, rsp_hit, rsp_idx
   );

   modport slave (
      input  cfg_we, cfg_idx, cfg_en, cfg_val, cfg_mask,
      input  req_valid, req_key, rsp_ready,
      output cfg_ready, req_ready, rsp_valid, rsp_hit, rsp_idx
   );
endinterface

// File: rtl/wildeq_scan.sv
// ---------------------------------------------------------------------------
// wildeq_scan
// Purpose : wildcard-equality lookup over a small pattern table. Each entry
//           holds a valid bit, a value and a don't-care mask; a key matches
//           an entry when every non-masked bit equals the value. A single
//           compare unit walks the table one entry per cycle and reports the
//           lowest matching index.
// Ports   : clk  - sole clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - wildeq_scan_if.slave (table write, request, response)
// Config  : WILDEQ_SCAN_EARLY_EXIT_EN - when defined, the scan stops at the
//           first hit (latency 2+k for a hit at entry k). When undefined the
//           whole table is always scanned (fixed latency 1+ENTRIES).
// ---------------------------------------------------------------------------
module wildeq_scan #(
   parameter int WIDTH   = 4,
   parameter int ENTRIES = 8
) (
   input  logic           clk,
   input  logic           rst,
   wildeq_scan_if.slave   bus
);
   localparam int IW = $clog2(ENTRIES);
   localparam logic [IW-1:0] LAST_IDX = IW'(ENTRIES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           r_state;
   logic [ENTRIES-1:0] r_en;
   logic [WIDTH-1:0] r_val  [ENTRIES];
   logic [WIDTH-1:0] r_mask [ENTRIES];
   logic [WIDTH-1:0] r_key;
   logic [IW-1:0]    r_ptr;
   logic             r_hit;
   logic [IW-1:0]    r_idx;
   logic             r_rsp_valid;

   logic w_idle;
   logic w_cfg_accept;
   logic w_match;
   logic w_first_hit;
   logic w_scan_done;

   assign w_idle       = (r_state == IDLE);
   assign w_cfg_accept = w_idle && bus.cfg_we;

   // Single compare unit, fed by the entry under the scan pointer.
   assign w_match = r_en[r_ptr] &&
                    (((r_key ^ r_val[r_ptr]) & ~r_mask[r_ptr]) == '0);

   // Only the first hit is recorded, which yields the lowest matching index.
   assign w_first_hit = w_match && !r_hit;

`ifdef WILDEQ_SCAN_EARLY_EXIT_EN
   assign w_scan_done = (r_ptr == LAST_IDX) || w_first_hit;
`else
   assign w_scan_done = (r_ptr == LAST_IDX);
`endif

   // Value/mask storage carries no reset; the valid bits alone gate matches.
   always_ff @(posedge clk) begin
      if (w_cfg_accept) begin
         r_val[bus.cfg_idx]  <= bus.cfg_val;
         r_mask[bus.cfg_idx] <= bus.cfg_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_en        <= '0;
         r_ptr       <= '0;
         r_hit       <= 1'b0;
         r_idx       <= '0;
         r_rsp_valid <= 1'b0;
         r_key       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // A table write wins over a same-cycle request.
               if (bus.cfg_we) begin
                  r_en[bus.cfg_idx] <= bus.cfg_en;
               end else if (bus.req_valid) begin
                  r_key   <= bus.req_key;
                  r_ptr   <= '0;
                  r_hit   <= 1'b0;
                  r_idx   <= '0;
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               if (w_first_hit) begin
                  r_hit <= 1'b1;
                  r_idx <= r_ptr;
               end
               if (w_scan_done) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_ptr       <= '0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cfg_ready = w_idle;
   assign bus.req_ready = w_idle && !bus.cfg_we;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_hit   = r_hit;
   assign bus.rsp_idx   = r_idx;
endmodule

// File: tb/tb_wildeq_scan.sv
// ---------------------------------------------------------------------------
// tb_wildeq_scan
// Directed bench for wildeq_scan (WIDTH=4, ENTRIES=8). Expected latencies
// follow the build: WILDEQ_SCAN_EARLY_EXIT_EN selects the early-exit numbers.
// ---------------------------------------------------------------------------
module tb_wildeq_scan;
   localparam int WIDTH   = 4;
   localparam int ENTRIES = 8;
   localparam int FULL_LAT = 1 + ENTRIES;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   wildeq_scan_if #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) bus ();

   wildeq_scan #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] idx, input logic [3:0] val,
                     input logic [3:0] mask, input logic en);
      bus.cfg_we   = 1'b1;
      bus.cfg_idx  = idx;
      bus.cfg_val  = val;
      bus.cfg_mask = mask;
      bus.cfg_en   = en;
      #1;
      chk("wr_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      tick();
      bus.cfg_we = 1'b0;
      $display("write idx=%0d val=%b mask=%b en=%0d", idx, val, mask, en);
   endtask

   // Issue one lookup, measure cycles from acceptance to rsp_valid, hold
   // rsp_ready low for 'hold' cycles checking stability, then complete.
   task automatic lookup(input string tag, input logic [3:0] key,
                         input logic exp_hit, input logic [2:0] exp_idx,
                         input int exp_lat, input int hold);
      int n;
      bus.req_valid = 1'b1;
      bus.req_key   = key;
      #1;
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      n = 1;
      while (bus.rsp_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_hit"}, 32'(bus.rsp_hit), 32'(exp_hit));
      chk({tag, "_idx"}, 32'(bus.rsp_idx), 32'(exp_idx));
      for (int h = 0; h < hold; h++) begin
         tick();
         chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
         chk({tag, "_hold_hit"}, 32'(bus.rsp_hit), 32'(exp_hit));
         chk({tag, "_hold_idx"}, 32'(bus.rsp_idx), 32'(exp_idx));
         chk({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
         chk({tag, "_hold_cfg_ready"}, 32'(bus.cfg_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      #1;
      chk({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_done_req_ready"}, 32'(bus.req_ready), 32'd1);
      $display("lookup %s key=%b hit=%0d idx=%0d latency=%0d", tag, key,
               exp_hit, exp_idx, n);
   endtask

   initial begin
      int  lat_hit3;
      int  lat_hit1;
      int  lat_hit0;
      logic seen;
      checks = 0;
      errors = 0;
`ifdef WILDEQ_SCAN_EARLY_EXIT_EN
      lat_hit3 = 5;
      lat_hit1 = 3;
      lat_hit0 = 2;
`else
      lat_hit3 = FULL_LAT;
      lat_hit1 = FULL_LAT;
      lat_hit0 = FULL_LAT;
`endif
      rst           = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_idx   = '0;
      bus.cfg_en    = 1'b0;
      bus.cfg_val   = '0;
      bus.cfg_mask  = '0;
      bus.req_valid = 1'b0;
      bus.req_key   = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_hit", 32'(bus.rsp_hit), 32'd0);
      chk("rst_rsp_idx", 32'(bus.rsp_idx), 32'd0);
      chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      $display("reset released");

      // Empty table: everything misses.
      lookup("empty", 4'b1010, 1'b0, 3'd0, FULL_LAT, 0);

      wr(3'd3, 4'b1000, 4'b0110, 1'b1);
      lookup("hit3", 4'b1010, 1'b1, 3'd3, lat_hit3, 0);
      lookup("miss", 4'b1011, 1'b0, 3'd0, FULL_LAT, 0);

      // Full-wildcard entry 1 shadows entry 3; exercise backpressure here.
      wr(3'd1, 4'b0000, 4'b1111, 1'b1);
      lookup("prio1", 4'b1010, 1'b1, 3'd1, lat_hit1, 5);
      wr(3'd1, 4'b0000, 4'b1111, 1'b0);
      lookup("prio3", 4'b1010, 1'b1, 3'd3, lat_hit3, 0);

      // Last entry boundary: exact match only at index 7.
      wr(3'd7, 4'b1111, 4'b0000, 1'b1);
      lookup("last7", 4'b1111, 1'b1, 3'd7, FULL_LAT, 0);

      // Write and request together: write wins, request goes next cycle.
      bus.cfg_we    = 1'b1;
      bus.cfg_idx   = 3'd0;
      bus.cfg_val   = 4'b1010;
      bus.cfg_mask  = 4'b0000;
      bus.cfg_en    = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_key   = 4'b1010;
      #1;
      chk("coll_req_ready", 32'(bus.req_ready), 32'd0);
      chk("coll_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      tick();
      bus.cfg_we = 1'b0;
      $display("collision write idx=0 accepted, request deferred");
      lookup("coll", 4'b1010, 1'b1, 3'd0, lat_hit0, 0);

      // Reset in the middle of a scan abandons it and clears the table.
      bus.req_valid = 1'b1;
      bus.req_key   = 4'b1010;
      tick();
      bus.req_valid = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (bus.rsp_valid === 1'b1) seen = 1'b1;
      end
      chk("rstscan_no_rsp", 32'(seen), 32'd0);
      chk("rstscan_req_ready", 32'(bus.req_ready), 32'd1);
      $display("reset during scan, rsp_valid seen=%0d", seen);
      lookup("cleared", 4'b1010, 1'b0, 3'd0, FULL_LAT, 0);
      lookup("cleared7", 4'b1111, 1'b0, 3'd0, FULL_LAT, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
